// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between the ALU (A) and load (M) writeback
// paths: one buffered entry per source, oldest-first grant, zero-register writes dropped.
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              Clk,
    input  logic              Rst,

    input  logic              AValid,
    output logic              AReady,
    input  logic [REG_W-1:0]  AReg,
    input  logic [DATA_W-1:0] AData,

    input  logic              MValid,
    output logic              MReady,
    input  logic [REG_W-1:0]  MReg,
    input  logic [DATA_W-1:0] MData,

    output logic              WE,
    output logic [REG_W-1:0]  WReg,
    output logic [DATA_W-1:0] Data,

    input  logic [REG_W-1:0]  QR1,
    input  logic [REG_W-1:0]  QR2,
    output logic              Hit1,
    output logic              Hit2
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    logic              full_a;
    logic              full_m;
    logic [REG_W-1:0]  reg_a;
    logic [REG_W-1:0]  reg_m;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_m;
    logic              old_a;
    logic              old_m;
    logic              rr_favor_m;

    logic              grant_a;
    logic              grant_m;
    logic              load_a;
    logic              load_m;
    logic              nxt_full_a;
    logic              nxt_full_m;
    logic              nxt_old_a;
    logic              nxt_old_m;

    // Oldest-first; round-robin only breaks ties between buffers loaded at the same edge.
    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (full_a && !full_m) begin
            grant_a = 1'b1;
        end else if (full_m && !full_a) begin
            grant_m = 1'b1;
        end else if (full_a && full_m) begin
            if (old_a) begin
                grant_a = 1'b1;
            end else if (old_m) begin
                grant_m = 1'b1;
            end else if (rr_favor_m) begin
                grant_m = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end
    end

    assign AReady = !full_a || grant_a;
    assign MReady = !full_m || grant_m;

    assign load_a = AValid && AReady && (AReg != ZERO_IDX);
    assign load_m = MValid && MReady && (MReg != ZERO_IDX);

    assign nxt_full_a = load_a || (full_a && !grant_a);
    assign nxt_full_m = load_m || (full_m && !grant_m);

    // The age flag only matters while both buffers are occupied.
    always_comb begin
        nxt_old_a = old_a;
        nxt_old_m = old_m;
        if (!nxt_full_a || !nxt_full_m) begin
            nxt_old_a = 1'b0;
            nxt_old_m = 1'b0;
        end else if (load_a && load_m) begin
            nxt_old_a = 1'b0;
            nxt_old_m = 1'b0;
        end else if (load_a) begin
            nxt_old_a = 1'b0;
            nxt_old_m = 1'b1;
        end else if (load_m) begin
            nxt_old_a = 1'b1;
            nxt_old_m = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            full_a <= 1'b0;
            full_m <= 1'b0;
            old_a  <= 1'b0;
            old_m  <= 1'b0;
            reg_a  <= '0;
            reg_m  <= '0;
            data_a <= '0;
            data_m <= '0;
        end else begin
            full_a <= nxt_full_a;
            full_m <= nxt_full_m;
            old_a  <= nxt_old_a;
            old_m  <= nxt_old_m;
            if (load_a) begin
                reg_a  <= AReg;
                data_a <= AData;
            end
            if (load_m) begin
                reg_m  <= MReg;
                data_m <= MData;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rr_favor_m <= 1'b0;
        end else if (grant_a) begin
            rr_favor_m <= 1'b1;
        end else if (grant_m) begin
            rr_favor_m <= 1'b0;
        end
    end

    // Write port register; index and data hold when nothing is granted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            WE   <= 1'b0;
            WReg <= '0;
            Data <= '0;
        end else begin
            WE <= grant_a || grant_m;
            if (grant_a) begin
                WReg <= reg_a;
                Data <= data_a;
            end else if (grant_m) begin
                WReg <= reg_m;
                Data <= data_m;
            end
        end
    end

    assign Hit1 = (QR1 != ZERO_IDX) &&
                  ((full_a && (reg_a == QR1)) ||
                   (full_m && (reg_m == QR1)) ||
                   (WE && (WReg == QR1)));

    assign Hit2 = (QR2 != ZERO_IDX) &&
                  ((full_a && (reg_a == QR2)) ||
                   (full_m && (reg_m == QR2)) ||
                   (WE && (WReg == QR2)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued at acceptance
// and popped by a monitor whenever the write port pulses WE.
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [4:0]  r;
        logic [63:0] d;
    } wr_t;

    logic        Clk;
    logic        Rst;
    logic        AValid;
    logic        AReady;
    logic [4:0]  AReg;
    logic [63:0] AData;
    logic        MValid;
    logic        MReady;
    logic [4:0]  MReg;
    logic [63:0] MData;
    logic        WE;
    logic [4:0]  WReg;
    logic [63:0] Data;
    logic [4:0]  QR1;
    logic [4:0]  QR2;
    logic        Hit1;
    logic        Hit2;

    int checks = 0;
    int failures = 0;
    int we_count = 0;
    wr_t sb[$];
    logic [63:0] rf [32];

    regfile_write_arbiter #(.DATA_W(64), .REG_W(5), .ZERO_REG(31)) dut (
        .Clk(Clk), .Rst(Rst),
        .AValid(AValid), .AReady(AReady), .AReg(AReg), .AData(AData),
        .MValid(MValid), .MReady(MReady), .MReg(MReg), .MData(MData),
        .WE(WE), .WReg(WReg), .Data(Data),
        .QR1(QR1), .QR2(QR2), .Hit1(Hit1), .Hit2(Hit2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: every write-port pulse must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (WE === 1'b1) begin
            wr_t e;
            we_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got reg=%0d data=%h, required no write", WReg, Data);
            end else begin
                e = sb.pop_front();
                if (WReg !== e.r || Data !== e.d) begin
                    failures++;
                    $display("FAIL write_order: got reg=%0d data=%h, required reg=%0d data=%h",
                             WReg, Data, e.r, e.d);
                end
            end
            rf[WReg] = Data;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        AValid = 1'b0;
        MValid = 1'b0;
        step();
        Rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        AValid = 1'b0; MValid = 1'b0;
        AReg = '0; AData = '0; MReg = '0; MData = '0;
        QR1 = 5'd0; QR2 = 5'd5;
        step();
        Rst = 1'b0;
        #1;
        checks++;
        if (WE !== 1'b0 || WReg !== 5'd0 || Data !== 64'd0) begin
            failures++;
            $display("FAIL reset_port: got WE=%b WReg=%0d Data=%h, required 0/0/0", WE, WReg, Data);
        end
        checks++;
        if (AReady !== 1'b1 || MReady !== 1'b1 || Hit1 !== 1'b0 || Hit2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_hit: got AReady=%b MReady=%b Hit1=%b Hit2=%b, required 1 1 0 0",
                     AReady, MReady, Hit1, Hit2);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        QR1 = 5'd5;
        AValid = 1'b1; AReg = 5'd5; AData = 64'h1122334455667788;
        #1;
        checks++;
        if (AReady !== 1'b1 || Hit1 !== 1'b0) begin
            failures++;
            $display("FAIL single_pre: got AReady=%b Hit1=%b, required 1 0", AReady, Hit1);
        end
        sb.push_back('{r: 5'd5, d: 64'h1122334455667788});
        step();
        AValid = 1'b0;
        #1;
        checks++;
        if (WE !== 1'b0 || Hit1 !== 1'b1) begin
            failures++;
            $display("FAIL single_buffered: got WE=%b Hit1=%b, required 0 1", WE, Hit1);
        end
        step();
        checks++;
        if (WE !== 1'b1 || WReg !== 5'd5 || Data !== 64'h1122334455667788 || Hit1 !== 1'b1) begin
            failures++;
            $display("FAIL single_write: got WE=%b WReg=%0d Data=%h Hit1=%b, required 1 5 1122334455667788 1",
                     WE, WReg, Data, Hit1);
        end
        step();
        checks++;
        if (WE !== 1'b0 || Hit1 !== 1'b0) begin
            failures++;
            $display("FAIL single_done: got WE=%b Hit1=%b, required 0 0", WE, Hit1);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL single_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_in_order();
        int start;
        do_reset();
        start = we_count;
        AValid = 1'b1; AReg = 5'd3; AData = 64'hA;
        #1;
        checks++;
        if (AReady !== 1'b1) begin
            failures++;
            $display("FAIL order_a_ready: got %b, required 1", AReady);
        end
        sb.push_back('{r: 5'd3, d: 64'hA});
        step();
        AValid = 1'b0;
        MValid = 1'b1; MReg = 5'd3; MData = 64'hB;
        #1;
        checks++;
        if (MReady !== 1'b1) begin
            failures++;
            $display("FAIL order_m_ready: got %b, required 1", MReady);
        end
        sb.push_back('{r: 5'd3, d: 64'hB});
        step();
        MValid = 1'b0;
        repeat (4) step();
        checks++;
        if (rf[3] !== 64'hB || we_count - start != 2 || sb.size() != 0) begin
            failures++;
            $display("FAIL order_final: got x3=%h writes=%0d pending=%0d, required b 2 0",
                     rf[3], we_count - start, sb.size());
        end
    endtask

    task automatic test_streaming();
        int na = 0;
        int nm = 0;
        do_reset();
        AValid = 1'b1; MValid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            AReg = 5'(1 + (na % 10));  AData = {32'hA0A0_0000, 32'(na)};
            MReg = 5'(11 + (nm % 10)); MData = {32'hB0B0_0000, 32'(nm)};
            #1;
            if (k == 0) begin
                checks++;
                if (AReady !== 1'b1 || MReady !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_start: got AReady=%b MReady=%b, required 1 1", AReady, MReady);
                end
                sb.push_back('{r: AReg, d: AData});
                sb.push_back('{r: MReg, d: MData});
                na++; nm++;
            end else begin
                checks++;
                if (AReady !== 1'((k % 2) == 1) || MReady !== 1'((k % 2) == 0)) begin
                    failures++;
                    $display("FAIL stream_ready k=%0d: got AReady=%b MReady=%b, required %b %b",
                             k, AReady, MReady, 1'((k % 2) == 1), 1'((k % 2) == 0));
                end
                if ((k % 2) == 1) begin
                    sb.push_back('{r: AReg, d: AData});
                    na++;
                end else begin
                    sb.push_back('{r: MReg, d: MData});
                    nm++;
                end
            end
            if (k >= 2) begin
                checks++;
                if (WE !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_we k=%0d: got %b, required 1", k, WE);
                end
            end
            step();
        end
        AValid = 1'b0; MValid = 1'b0;
        repeat (4) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL stream_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_zero_reg();
        int start;
        start = we_count;
        QR1 = 5'd31;
        AValid = 1'b1; AReg = 5'd31; AData = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (AReady !== 1'b1 || Hit1 !== 1'b0) begin
                failures++;
                $display("FAIL zero_ready k=%0d: got AReady=%b Hit1=%b, required 1 0", k, AReady, Hit1);
            end
            step();
        end
        AValid = 1'b0;
        repeat (3) step();
        checks++;
        if (we_count != start) begin
            failures++;
            $display("FAIL zero_no_write: got %0d writes, required 0", we_count - start);
        end
    endtask

    task automatic test_reset_midop();
        int start;
        AValid = 1'b1; AReg = 5'd7; AData = 64'h7777;
        MValid = 1'b1; MReg = 5'd8; MData = 64'h8888;
        step();
        AValid = 1'b0; MValid = 1'b0;
        QR1 = 5'd7; QR2 = 5'd8;
        #1;
        checks++;
        if (Hit1 !== 1'b1 || Hit2 !== 1'b1) begin
            failures++;
            $display("FAIL midop_full: got Hit1=%b Hit2=%b, required 1 1", Hit1, Hit2);
        end
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        sb.delete();
        start = we_count;
        checks++;
        if (WE !== 1'b0 || WReg !== 5'd0 || Data !== 64'd0 || AReady !== 1'b1 || MReady !== 1'b1 ||
            Hit1 !== 1'b0 || Hit2 !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: got WE=%b WReg=%0d Data=%h AR=%b MR=%b H1=%b H2=%b, required 0 0 0 1 1 0 0",
                     WE, WReg, Data, AReady, MReady, Hit1, Hit2);
        end
        repeat (4) step();
        checks++;
        if (we_count != start) begin
            failures++;
            $display("FAIL midop_discard: got %0d writes, required 0", we_count - start);
        end
    endtask

    task automatic test_oldest_first();
        do_reset();
        AValid = 1'b1; AReg = 5'd1; AData = 64'hA0;
        MValid = 1'b1; MReg = 5'd2; MData = 64'hB0;
        #1;
        sb.push_back('{r: 5'd1, d: 64'hA0});
        sb.push_back('{r: 5'd2, d: 64'hB0});
        step();
        MValid = 1'b0;
        AReg = 5'd4; AData = 64'hA1;
        #1;
        checks++;
        if (AReady !== 1'b1 || MReady !== 1'b0) begin
            failures++;
            $display("FAIL age_tie: got AReady=%b MReady=%b, required 1 0", AReady, MReady);
        end
        sb.push_back('{r: 5'd4, d: 64'hA1});
        step();
        AReg = 5'd5; AData = 64'hA2;
        #1;
        checks++;
        if (AReady !== 1'b0 || MReady !== 1'b1) begin
            failures++;
            $display("FAIL age_older_m: got AReady=%b MReady=%b, required 0 1", AReady, MReady);
        end
        step();
        checks++;
        if (AReady !== 1'b1) begin
            failures++;
            $display("FAIL age_a_alone: got AReady=%b, required 1", AReady);
        end
        sb.push_back('{r: 5'd5, d: 64'hA2});
        step();
        AValid = 1'b0;
        repeat (4) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL age_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_in_order();
        test_streaming();
        test_zero_reg();
        test_reset_midop();
        test_oldest_first();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback sources: the ALU result path (requester A) and the load-data path (requester M). Each source hands over a destination index and 64-bit value with a valid/ready handshake. The block buffers one entry per source, grants the write port oldest-first, and drops writes to the zero register (X31). It also reports pending writes to queried read indices, so decode can stall or forward.

## Interface
- DATA_W, 64, write data width
- REG_W, 5, register index width
- ZERO_REG, 31, index whose writes are discarded
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, synchronous, active-high
- AValid  in  1  ALU write request
- AReady  out  1  ALU request accepted this cycle when AValid&AReady
- AReg  in  REG_W  ALU destination index
- AData  in  DATA_W  ALU write value
- MValid  in  1  load write request
- MReady  out  1  load request accepted when MValid&MReady
- MReg  in  REG_W  load destination index
- MData  in  DATA_W  load write value
- WE  out  1  register file write enable (registered)
- WReg  out  REG_W  register file write index (registered)
- Data  out  DATA_W  register file write data (registered)
- QR1, QR2  in  REG_W  read indices under query
- Hit1, Hit2  out  1  queried index has a pending write (combinational)

## Operation
- Per source: one-entry buffer {full, reg, data, age}.
- Acceptance:
  - AReady = !fullA | grantA.
  - MReady = !fullM | grantM.
- Accept with reg == ZERO_REG: the handshake completes and the write is discarded. The buffer is not loaded; if it was being drained this cycle, it becomes empty.
- Any other accept loads the buffer, full=1.
- Age: a 1-bit "older" flag marks which full buffer was loaded first.
  - A buffer loaded while the other stays full is younger.
  - If both are loaded at the same edge, neither is older.
- Grant (combinational, at most one per cycle):
  - Only one buffer full: grant it.
  - Both full, one older: grant the older.
  - Both full, same age: round-robin. Grant the source not granted last. The pointer updates on every grant; after reset it favours A.
- The granted buffer loads {WE=1, WReg, Data} at the next edge and clears full, unless refilled the same edge. With no grant, WE=0 at the next edge; WReg/Data hold.
- Same-destination pairs are therefore written in acceptance order. For a same-edge pair, the round-robin order applies; sources must not issue same-edge writes to one register.
- Hit1 = (fullA & regA==QR1) | (fullM & regM==QR1) | (WE & WReg==QR1). Hit2 is the same function on QR2.
- Hit is never asserted for QR == ZERO_REG.

## Timing
- Reset (Rst high at an edge):
  - fullA = fullM = 0, WE = 0, WReg = 0, Data = 0, round-robin pointer favours A.
  - AReady = MReady = 1 and Hit1 = Hit2 = 0 in the following cycle.
- Reset mid-operation discards buffered and in-flight writes. A WE pulse already visible in the reset cycle is still sampled by the register file at that edge.
- Latency: accepted at edge t → WE/WReg/Data valid in cycle t+1..t+2 (loaded at edge t+1) → register file writes at edge t+2. This is the minimum; contention adds one cycle per lost arbitration.
- Throughput: one write per cycle total. An uncontested source sustains 1 per cycle with AReady held high.
- With both sources streaming, each gets 1 per 2 cycles and ready alternates.
- AReady/MReady depend only on state and the current grant, never on AValid/MValid.

## Test plan
- Reset, then AValid=1, AReg=5, AData=0x1122334455667788 for one cycle → WE=1, WReg=5, Data=0x1122334455667788 exactly one cycle after acceptance; Hit1=1 with QR1=5 from acceptance until WE drops.
- A then M each accepted once on back-to-back cycles (A: X3=0xA, M: X3=0xB, M one cycle later) while the port is busy → writes appear in order X3=0xA then X3=0xB; final register value 0xB.
- Both sources stream continuously with distinct registers → WE=1 every cycle; grants alternate A,M,A,M; each ready toggles every cycle.
- AReg=31, AData=0xFFFF… accepted → no WE pulse; Hit1=0 with QR1=31; buffer A stays empty and AReady remains 1.
- Both buffers full, Rst asserted for one edge → next cycle WE=0, WReg=0, Data=0, AReady=MReady=1, Hit1=Hit2=0; neither buffered write ever reaches the port.
- M buffer held full while A is granted every cycle for 3 cycles → M is granted no later than the first cycle after A's buffer is younger than M's (the oldest-first rule prevents starvation).
